// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared fetch-stage state encoding and default widths
package instr_fetch_pkg;
  localparam int DEF_PC_W = 10;
  localparam int DEF_START_ADDR = 0;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_e;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: harness/decode <-> fetch-stage signals; slave is the fetch stage
interface instr_fetch_if #(
  parameter int PC_W = instr_fetch_pkg::DEF_PC_W,
  parameter int CNT_W = instr_fetch_pkg::DEF_CNT_W
);
  logic start;
  logic stall;
  logic halt;
  logic branch;
  logic branch_abs;
  logic [7:0] target;
  logic [PC_W-1:0] pc;
  logic instr_valid;
  logic done;
  logic [CNT_W-1:0] cycle_cnt;
  modport master (
    output start, stall, halt, branch, branch_abs, target,
    input pc, instr_valid, done, cycle_cnt
  );
  modport slave (
    input start, stall, halt, branch, branch_abs, target,
    output pc, instr_valid, done, cycle_cnt
  );
endinterface

// File: rtl/instr_fetch_branch_lut.sv
// branch_lut: 32-entry table of signed relative branch offsets
module branch_lut #(
  parameter int PC_W = instr_fetch_pkg::DEF_PC_W
) (
  input  logic [4:0]      idx,
  output logic [PC_W-1:0] offset
);
  // unlisted entries fall back to the index itself, sign-extended
  always_comb begin
    case (idx)
      5'd0:    offset = PC_W'(0);
      5'd1:    offset = PC_W'(2);
      5'd2:    offset = PC_W'(-2);
      5'd3:    offset = PC_W'(300);
      5'd4:    offset = PC_W'(-300);
      5'd5:    offset = PC_W'(511);
      5'd6:    offset = PC_W'(-512);
      5'd7:    offset = PC_W'(128);
      5'd8:    offset = PC_W'(-129);
      5'd9:    offset = PC_W'(64);
      5'd10:   offset = PC_W'(-64);
      default: offset = PC_W'($signed(idx));
    endcase
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC sequencer with branch/halt, start/done handshake and run-cycle counter; FETCH_LUT_EN selects table-driven relative offsets
module instr_fetch import instr_fetch_pkg::*; #(
  parameter int PC_W = DEF_PC_W,
  parameter int START_ADDR = DEF_START_ADDR,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  instr_fetch_if.slave bus
);
  fetch_state_e state, state_n;
  logic [PC_W-1:0] pc, pc_n, rel_off;
  logic [CNT_W-1:0] cnt, cnt_n;
`ifdef FETCH_LUT_EN
  branch_lut #(.PC_W(PC_W)) u_lut (.idx(bus.target[4:0]), .offset(rel_off));
`else
  assign rel_off = PC_W'($signed(bus.target));
`endif
  // state, PC and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      cnt <= cnt_n;
    end
  end
  // next state: stall > halt > branch > sequential; start only outside RUN
  always_comb begin
    state_n = state;
    pc_n = pc;
    cnt_n = cnt;
    if (state == RUN) begin
      cnt_n = &cnt ? cnt : cnt + CNT_W'(1);
      if (!bus.stall) begin
        state_n = bus.halt ? HALTED : RUN;
        pc_n = bus.halt ? pc : !bus.branch ? pc + PC_W'(1) :
               bus.branch_abs ? PC_W'(bus.target) : pc + rel_off;
      end
    end else if (bus.start) begin
      state_n = RUN;
      pc_n = PC_W'(START_ADDR);
      cnt_n = '0;
    end
  end
  assign bus.pc = pc;
  assign bus.instr_valid = (state == RUN);
  assign bus.done = (state == HALTED);
  assign bus.cycle_cnt = cnt;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized + directed scoreboard bench for instr_fetch
module tb_instr_fetch;
  localparam int PW = 10;
  localparam int CW = 16;
  localparam int SA = 0;
  localparam int PM = 1 << PW;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct {
    logic [PW-1:0] pc;
    logic v;
    logic d;
    logic [CW-1:0] c;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  bit m_run, m_halt;
  int m_pc, m_cnt;
  always #5 clk = ~clk;
  instr_fetch_if bus ();
  instr_fetch dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic int rel(logic [7:0] t);
`ifdef FETCH_LUT_EN
    case (t[4:0])
      5'd0: return 0;
      5'd1: return 2;
      5'd2: return -2;
      5'd3: return 300;
      5'd4: return -300;
      5'd5: return 511;
      5'd6: return -512;
      5'd7: return 128;
      5'd8: return -129;
      5'd9: return 64;
      5'd10: return -64;
      default: return int'($signed(t[4:0]));
    endcase
`else
    return int'($signed(t));
`endif
  endfunction

  task automatic model_reset();
    m_run = 0;
    m_halt = 0;
    m_pc = 0;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    if (m_run) begin
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (!bus.stall) begin
        if (bus.halt) begin
          m_run = 0;
          m_halt = 1;
        end else if (bus.branch)
          m_pc = bus.branch_abs ? int'(bus.target) : (m_pc + rel(bus.target) + PM) % PM;
        else
          m_pc = (m_pc + 1) % PM;
      end
    end else if (bus.start) begin
      m_run = 1;
      m_halt = 0;
      m_pc = SA;
      m_cnt = 0;
    end
  endtask

  task automatic push();
    exp_t e;
    e.pc = PW'(m_pc);
    e.v = m_run;
    e.d = m_halt;
    e.c = CW'(m_cnt);
    q.push_back(e);
  endtask

  task automatic cyc(input bit s, st, h, b, a, input logic [7:0] t, input bit rp = 0);
    bus.start = s;
    bus.stall = st;
    bus.halt = h;
    bus.branch = b;
    bus.branch_abs = a;
    bus.target = t;
    @(posedge clk);
    #1;
    model_edge();
    if (rp) begin
      rst = 1;
      #2;
      rst = 0;
      model_reset();
    end
    push();
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endtask

  // scoreboard monitor: one expected output set per cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", 32'(bus.pc), 32'(e.pc));
      chk("instr_valid", 32'(bus.instr_valid), 32'(e.v));
      chk("done", 32'(bus.done), 32'(e.d));
      chk("cycle_cnt", 32'(bus.cycle_cnt), 32'(e.c));
    end
  end

  initial begin
    bus.start = 0;
    bus.stall = 0;
    bus.halt = 0;
    bus.branch = 0;
    bus.branch_abs = 0;
    bus.target = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    push();
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    repeat (5) cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 1, 8'h10);
    cyc(0, 0, 0, 1, 0, 8'hFC);
    cyc(0, 0, 0, 1, 1, 8'h80);
    cyc(0, 0, 0, 1, 1, 8'h00);
    cyc(0, 0, 0, 1, 0, 8'hFF);
    repeat (3) cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 0, 8'hF0);
    repeat (3) cyc(0, 1, 1, 0, 0, 8'h00);
    cyc(1, 0, 1, 1, 1, 8'h55);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 1, 8'h10);
    cyc(0, 0, 0, 1, 0, 8'h03);
    cyc(0, 0, 0, 1, 1, 8'h23);
    cyc(0, 1, 0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    repeat (400)
      cyc(bit'($urandom_range(0, 9) < 2), bit'($urandom_range(0, 9) < 2),
          bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 9) < 3),
          bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 99) == 0));
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
